lcd_hex_writer: RTL and testbench

LCD_HEX_WRITER -- requirements
Module: lcd_hex_writer

---
 rtl/lcd_hex_writer.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_hex_writer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hex_writer.sv
// Writes a SIZE_DATA_IN-bit word as upper-case hex on an HD44780-style 8-bit LCD.
// Define LCD_HEX_PREFIX_EN to emit a "0x" prefix between the address command and the digits.
module lcd_hex_writer #(
  parameter int unsigned SIZE_DATA_IN = 16,
  parameter int unsigned T_PWRUP      = 750_000,
  parameter int unsigned T_EN         = 12,
  parameter int unsigned T_CMD        = 2_000,
  parameter int unsigned T_CLR        = 82_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [SIZE_DATA_IN-1:0] i_data,
  input  logic                    i_line,
  output logic                    o_ready,
  output logic                    o_done,
  output logic [7:0]              o_LCD_DATA,
  output logic                    o_LCD_E,
  output logic                    o_LCD_RW,
  output logic                    o_LCD_RS,
  output logic                    o_LCD_ON,
  output logic                    o_LCD_BLON
);

  localparam int unsigned NUM_NIB = SIZE_DATA_IN / 4;
  localparam int unsigned NIB_W   = $clog2(NUM_NIB) + 1;
  localparam int unsigned T_MAX_A = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int unsigned T_MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned WAIT_W  = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {PWRUP, SETUP, E_HI, WAIT, IDLE} state_t;

  // Points at the byte to be written after the current one completes its WAIT.
  typedef enum logic [2:0] {
    SqInit,
    SqDigit,
    SqEndInit,
    SqEndTx
`ifdef LCD_HEX_PREFIX_EN
    , SqPre0,
    SqPre1
`endif
  } seq_t;

  state_t                  state;
  seq_t                    seq_q;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [NIB_W-1:0]        nib_cnt;
  logic [1:0]              init_idx;
  logic [SIZE_DATA_IN-1:0] data_q;

  logic [7:0] nxt_byte;
  logic       nxt_rs;
  logic       is_clr;
  logic       wait_end;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign o_LCD_RW   = 1'b0;
  assign o_LCD_ON   = 1'b1;
  assign o_LCD_BLON = 1'b1;

  always_comb begin
    nxt_byte = 8'h00;
    nxt_rs   = 1'b1;
    case (seq_q)
      SqInit: begin
        nxt_byte = init_byte(init_idx);
        nxt_rs   = 1'b0;
      end
      SqDigit: nxt_byte = hex_char(data_q[SIZE_DATA_IN-1 -: 4]);
`ifdef LCD_HEX_PREFIX_EN
      SqPre0:  nxt_byte = 8'h30;
      SqPre1:  nxt_byte = 8'h78;
`endif
      default: nxt_rs = 1'b0;
    endcase
  end

  // Clear-display needs the long settle time; everything else uses T_CMD.
  assign is_clr   = (o_LCD_DATA == 8'h01) && !o_LCD_RS;
  assign wait_end = is_clr ? (wait_cnt == WAIT_W'(T_CLR - 1)) : (wait_cnt == WAIT_W'(T_CMD - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= PWRUP;
      seq_q      <= SqInit;
      wait_cnt   <= '0;
      nib_cnt    <= '0;
      init_idx   <= '0;
      data_q     <= '0;
      o_LCD_DATA <= 8'h00;
      o_LCD_E    <= 1'b0;
      o_LCD_RS   <= 1'b0;
      o_ready    <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        PWRUP: begin
          if (wait_cnt == WAIT_W'(T_PWRUP - 1)) begin
            wait_cnt   <= '0;
            o_LCD_DATA <= init_byte(2'd0);
            o_LCD_RS   <= 1'b0;
            init_idx   <= 2'd1;
            seq_q      <= SqInit;
            state      <= SETUP;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        SETUP: begin
          o_LCD_E <= 1'b1;
          state   <= E_HI;
        end

        E_HI: begin
          if (wait_cnt == WAIT_W'(T_EN - 1)) begin
            wait_cnt <= '0;
            o_LCD_E  <= 1'b0;
            state    <= WAIT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        WAIT: begin
          if (wait_end) begin
            wait_cnt <= '0;
            if (seq_q == SqEndInit || seq_q == SqEndTx) begin
              state   <= IDLE;
              o_ready <= 1'b1;
              o_done  <= (seq_q == SqEndTx);
            end else begin
              o_LCD_DATA <= nxt_byte;
              o_LCD_RS   <= nxt_rs;
              state      <= SETUP;
              case (seq_q)
                SqInit: begin
                  if (init_idx == 2'd3) begin
                    seq_q <= SqEndInit;
                  end else begin
                    init_idx <= init_idx + 2'd1;
                  end
                end
                SqDigit: begin
                  data_q <= data_q << 4;
                  if (nib_cnt == NIB_W'(NUM_NIB - 1)) begin
                    seq_q <= SqEndTx;
                  end else begin
                    nib_cnt <= nib_cnt + NIB_W'(1);
                  end
                end
`ifdef LCD_HEX_PREFIX_EN
                SqPre0:  seq_q <= SqPre1;
                SqPre1:  seq_q <= SqDigit;
`endif
                default: seq_q <= SqEndTx;
              endcase
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        IDLE: begin
          if (i_start) begin
            o_ready    <= 1'b0;
            data_q     <= i_data;
            nib_cnt    <= '0;
            o_LCD_DATA <= i_line ? 8'hC0 : 8'h80;
            o_LCD_RS   <= 1'b0;
`ifdef LCD_HEX_PREFIX_EN
            seq_q      <= SqPre0;
`else
            seq_q      <= SqDigit;
`endif
            state      <= SETUP;
          end
        end

        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Randomized self-checking bench for lcd_hex_writer; expected byte streams and timing come
// from a high-level model of the LCD write protocol.
module tb_lcd_hex_writer;

  localparam int SW      = 16;
  localparam int T_PWRUP = 20;
  localparam int T_EN    = 3;
  localparam int T_CMD   = 5;
  localparam int T_CLR   = 10;
  localparam int ND      = SW / 4;
`ifdef LCD_HEX_PREFIX_EN
  localparam int PRE     = 2;
`else
  localparam int PRE     = 0;
`endif
  localparam int PER     = 1 + T_EN + T_CMD;
  localparam int LAT     = (1 + ND + PRE) * PER + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [SW-1:0] data;
  logic          line;
  logic          ready;
  logic          done;
  logic [7:0]    lcd_data;
  logic          lcd_e;
  logic          lcd_rw;
  logic          lcd_rs;
  logic          lcd_on;
  logic          lcd_blon;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [8:0] byte_q[$];
  int         rise_q[$];
  logic [8:0] exp_q[$];
  logic       e_prev;
  int         e_len;
  logic [8:0] e_hold;

  lcd_hex_writer #(
    .SIZE_DATA_IN(SW),
    .T_PWRUP     (T_PWRUP),
    .T_EN        (T_EN),
    .T_CMD       (T_CMD),
    .T_CLR       (T_CLR)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_data     (data),
    .i_line     (line),
    .o_ready    (ready),
    .o_done     (done),
    .o_LCD_DATA (lcd_data),
    .o_LCD_E    (lcd_e),
    .o_LCD_RW   (lcd_rw),
    .o_LCD_RS   (lcd_rs),
    .o_LCD_ON   (lcd_on),
    .o_LCD_BLON (lcd_blon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus monitor: one entry {rs, data} per E pulse.
  always @(negedge clk) begin
    if (rst) begin
      e_prev <= 1'b0;
      e_len  <= 0;
    end else begin
      e_prev <= lcd_e;
      if (lcd_e && !e_prev) begin
        byte_q.push_back({lcd_rs, lcd_data});
        rise_q.push_back(cyc);
        e_hold <= {lcd_rs, lcd_data};
        e_len  <= 1;
        check("rw_low", 64'(lcd_rw), 64'd0);
        check("on_blon", 64'({lcd_on, lcd_blon}), 64'd3);
      end else if (lcd_e) begin
        e_len <= e_len + 1;
      end
      if (!lcd_e && e_prev) begin
        check("e_width", 64'(e_len), 64'(T_EN));
        check("data_hold", 64'({lcd_rs, lcd_data}), 64'(e_hold));
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  function automatic logic [SW-1:0] rand_word();
    return SW'({$urandom, $urandom});
  endfunction

  // Address, optional "0x", then one ASCII hex digit per nibble, MSB first.
  task automatic build_exp(input logic [SW-1:0] w, input logic ln);
    logic [63:0] wx;
    logic [7:0]  d;
    exp_q.delete();
    exp_q.push_back({1'b0, ln ? 8'hC0 : 8'h80});
`ifdef LCD_HEX_PREFIX_EN
    exp_q.push_back({1'b1, 8'h30});
    exp_q.push_back({1'b1, 8'h78});
`endif
    wx = 64'(w);
    for (int i = 0; i < ND; i++) begin
      d = 8'((wx >> (4 * (ND - 1 - i))) & 64'hF);
      exp_q.push_back({1'b1, (d < 8'd10) ? (8'h30 + d) : (8'h41 + d - 8'd10)});
    end
  endtask

  task automatic cmp_bytes(input string tag);
    check({tag, "_nbytes"}, 64'(byte_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < byte_q.size()) check($sformatf("%s_byte%0d", tag, k), 64'(byte_q[k]), 64'(exp_q[k]));
    end
  endtask

  task automatic wait_ready(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      if (ready) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) check("ready_timeout", 64'(ready), 64'd1);
  endtask

  // Called at the negedge where reset was released; rel is the cycle number of that period.
  task automatic check_init(input int rel);
    logic [8:0] exp_init[4];
    int         t;
    int         rise0;
    exp_init = '{9'h038, 9'h00C, 9'h006, 9'h001};
    rise0 = rel + T_PWRUP + 1;
    wait_ready(300, t);
    check("init_ready_cyc", 64'(t), 64'(rise0 + 3 * PER + T_EN + T_CLR));
    check("init_nbytes", 64'(byte_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < byte_q.size()) begin
        check($sformatf("init_byte%0d", k), 64'(byte_q[k]), 64'(exp_init[k]));
        check($sformatf("init_rise%0d", k), 64'(rise_q[k]), 64'(rise0 + k * PER));
      end
    end
  endtask

  task automatic do_txn(input logic [SW-1:0] w, input logic ln, input bit noise);
    int acc;
    int t;
    int d0;
    int nb;
    build_exp(w, ln);
    byte_q.delete();
    d0    = done_cnt;
    data  = w;
    line  = ln;
    start = 1'b1;
    acc   = cyc;
    @(negedge clk);
    start = 1'b0;
    check("ready_drop", 64'(ready), 64'd0);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        t = cyc;
        break;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        data  = rand_word();
        line  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (t < 0) check("done_timeout", 64'(done), 64'd1);
    check("latency", 64'(t - acc), 64'(LAT));
    check("ready_at_done", 64'(ready), 64'd1);
    cmp_bytes("txn");
    @(negedge clk);
    check("done_width", 64'(done), 64'd0);
    nb = byte_q.size();
    repeat (20) @(negedge clk);
    check("no_queued_bytes", 64'(byte_q.size()), 64'(nb));
    check("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic reset_mid_write();
    int d0;
    int rel;
    int tgt;
    bit hit;
    tgt = 3 + PRE;
    byte_q.delete();
    d0    = done_cnt;
    data  = rand_word();
    line  = 1'($urandom_range(0, 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (byte_q.size() >= tgt) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) check("rst_target_timeout", 64'(byte_q.size()), 64'(tgt));
    check("rst_e_before", 64'(lcd_e), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_e_drop", 64'(lcd_e), 64'd0);
    check("rst_data", 64'(lcd_data), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    byte_q.delete();
    rise_q.delete();
    check_init(rel);
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
  endtask

  // i_start stays high: each o_done cycle must also be the next accept cycle.
  task automatic back_to_back(input int n);
    logic [SW-1:0] w;
    logic          ln;
    int            acc;
    int            t;
    w = rand_word();
    ln = 1'($urandom_range(0, 1));
    build_exp(w, ln);
    byte_q.delete();
    data  = w;
    line  = ln;
    start = 1'b1;
    acc   = cyc;
    for (int k = 0; k < n; k++) begin
      t = -1;
      @(negedge clk);
      for (int i = 0; i < 400; i++) begin
        if (done) begin
          t = cyc;
          break;
        end
        @(negedge clk);
      end
      if (t < 0) check("b2b_timeout", 64'(done), 64'd1);
      check("b2b_latency", 64'(t - acc), 64'(LAT));
      check("b2b_rw", 64'(lcd_rw), 64'd0);
      cmp_bytes("b2b");
      w  = rand_word();
      ln = 1'($urandom_range(0, 1));
      build_exp(w, ln);
      byte_q.delete();
      data = w;
      line = ln;
      acc  = cyc;
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_ready_after", 64'(ready), 64'd1);
  endtask

  initial begin
    int rel;
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    line  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready0", 64'(ready), 64'd0);
    check("rst_done0", 64'(done), 64'd0);
    check("rst_e0", 64'(lcd_e), 64'd0);
    check("rst_rs0", 64'(lcd_rs), 64'd0);
    check("rst_data0", 64'(lcd_data), 64'd0);
    check("rst_rw0", 64'(lcd_rw), 64'd0);
    check("rst_on0", 64'({lcd_on, lcd_blon}), 64'd3);

    rst = 1'b0;
    rel = cyc;
    byte_q.delete();
    rise_q.delete();
    check_init(rel);

    do_txn(16'hA5C3, 1'b1, 1'b0);
    do_txn(16'h00FF, 1'b0, 1'b0);
    do_txn(16'h0000, 1'b0, 1'b0);
    do_txn(16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_txn(rand_word(), 1'($urandom_range(0, 1)), 1'b1);

    reset_mid_write();
    back_to_back(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
